ctrl_seq: RTL
=============

// Module: ctrl_seq
// PURPOSE
//  Parametrised multi-cycle control sequencer for the 32-bit bus-based CPU datapath.
//  Fetches the instruction, decodes IR, and steps a per-class micro-sequence. Drives a
//  packed control word plus ALUselect each cycle.
//  Adds three things: a memory wait-state handshake, stop honoured at instruction
//  boundaries, and a bounded memory-wait timeout with a fault state.
//  Clocked Moore machine; all outputs are registered. No #delays.
// PARAMETERS
//  IR_W       32  instruction register width
//  OPC_MSB    31  MSB of opcode field in IR
//  OPC_W      5   opcode field width
//  ALU_SEL_W  4   ALUselect width
//  WAIT_MAX   15  max cycles a read/wren step may wait for mem_ack before fault (>=1)
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          synchronous, active-high reset
//  IR         in   IR_W       instruction register contents
//  stop       in   1          halt request; any-cycle pulse, latched
//  conffout   in   1          branch-condition flag from CON FF
//  mem_ack    in   1          memory done; sampled only while ctrl.read or ctrl.wren = 1
//  ctrl       out  CTRL_W     packed control word; bit map in ctrl_pkg
//  ALUselect  out  ALU_SEL_W  ALU operation code
//  Run        out  1          1 while executing; 0 in reset, HALT, FAULT
//  fault      out  1          sticky memory-timeout or illegal-opcode indicator
// BEHAVIOUR
//  Reset: next edge forces S_RESET with ctrl=0, ALUselect=0, Run=0, fault=0, step=0,
//   stop latch=0, wait count=0. Reset wins over every other event, including mid-wait
//   and mid-instruction.
//  States: S_RESET -> S_T0 -> S_T1 -> S_T2 -> S_EXEC(step 3..7) -> S_T0 | S_HALT | S_FAULT.
//  S_RESET: clr=1 for one cycle. Run=1 from S_T0 onward.
//  S_T0:  PCout MARin Zin, ALUselect=0100 (PC+1).
//  S_T1:  ZLowout PCin read MDRin. Holds until mem_ack.
//  S_T2:  MDRout IRin.
//  At end of S_T2, decode IR[OPC_MSB-:OPC_W]; opcodes 0..26 follow the existing ISA map.
//  Exec step counts:
//   ld/st 5; mul/div/br 4; add/sub/and/or/sh/rot/imm/neg/not 3; jal 2;
//   jr/in/out/mfhi/mflo/nop 1; halt -> S_HALT.
//  ld:  Grb BAout Yin | Cout Zin ALU=0001 | ZLowout MARin | read MDRin (wait) | MDRout Gra Rin.
//  st:  same first 3 steps | Gra Rout MDRin | wren (wait).
//  mul/div: Gra Rout Yin | Grb Rout Zin ALU=0011/0101 | ZLowout LOin | ZHighout HIin.
//  br:  Gra Rout conffin | PCout Yin | Cout Zin ALU=0001 | ZLowout + PCin only if conffout=1.
//  Control signals are valid for the whole cycle in which they are asserted; nothing
//   carries over between steps.
//  Mem wait: while read/wren is asserted and mem_ack=0, hold the state and increment
//   the wait count. mem_ack=1 advances on the next edge and clears the count.
//  Timeout: count reaching WAIT_MAX with no ack -> S_FAULT: ctrl=0, fault=1, Run=0.
//   Only reset exits S_FAULT.
//  stop: latched in any state. Takes effect only when the last exec step completes:
//   -> S_HALT instead of S_T0.
//  S_HALT: ctrl=0, Run=0. Only reset exits. stop is ignored in S_RESET.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined:   opcode >26 after S_T2 -> S_FAULT with fault=1.
//  CTRL_ILLEGAL_TRAP_EN undefined: opcode >26 executes as nop (1 empty step), then S_T0.
// STRUCTURE
//  ctrl_pkg:   CTRL_W and bit indices for Gra Grb Grc Rin Rout BAout Cout MDRin MDRout
//              ZLowout ZHighout PCin PCout IRin HIin HIout LOin LOout InPortout OPin
//              Yin Zin IncPC MARin read wren clr conffin; opcode enum; ALU code
//              constants; state enum.
//  ctrl_decode: combinational submodule, opcode -> {class, alu code, step count, illegal}.
//  ctrl_seq:   holds state, step counter, wait counter, stop latch and output registers.
// TESTING
//  1 add (op 00011), mem_ack in the same cycle as read -> 6 cycles T0..T5; T4 has
//    ALUselect=0001 with Zin=1; T5 has Gra ZLowout Rin; then back to S_T0.
//  2 ld with mem_ack delayed 3 cycles in S_T1 and at step 6 -> both states held exactly
//    3 extra cycles; total 14 cycles; wait count 0 after each ack.
//  3 br with conffout=0, then conffout=1 -> PCin=0 / PCin=1 in step 6; ZLowout=1 both.
//  4 stop pulsed during step 4 of mul -> steps 5 and 6 still complete; then S_HALT,
//    Run=0, ctrl=0, held for 20 cycles.
//  5 mem_ack held 0 for WAIT_MAX=15 cycles in S_T1 -> S_FAULT, fault=1, Run=0;
//    reset -> S_RESET, fault=0.
//  6 opcode 11111 -> fault=1 with the macro defined; one empty step then S_T0 without it.
//    Also assert reset during a ld step-6 wait -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control sequencer: control-word bit map, ISA opcodes, ALU codes, class and state enums.
// No logic, so no latency.
// No flow control.
package ctrl_pkg;

  // Control-word bit positions
  localparam int B_GRA       = 0;
  localparam int B_GRB       = 1;
  localparam int B_GRC       = 2;
  localparam int B_RIN       = 3;
  localparam int B_ROUT      = 4;
  localparam int B_BAOUT     = 5;
  localparam int B_COUT      = 6;
  localparam int B_MDRIN     = 7;
  localparam int B_MDROUT    = 8;
  localparam int B_ZLOWOUT   = 9;
  localparam int B_ZHIGHOUT  = 10;
  localparam int B_PCIN      = 11;
  localparam int B_PCOUT     = 12;
  localparam int B_IRIN      = 13;
  localparam int B_HIIN      = 14;
  localparam int B_HIOUT     = 15;
  localparam int B_LOIN      = 16;
  localparam int B_LOOUT     = 17;
  localparam int B_INPORTOUT = 18;
  localparam int B_OPIN      = 19;
  localparam int B_YIN       = 20;
  localparam int B_ZIN       = 21;
  localparam int B_INCPC     = 22;
  localparam int B_MARIN     = 23;
  localparam int B_READ      = 24;
  localparam int B_WREN      = 25;
  localparam int B_CLR       = 26;
  localparam int B_CONFFIN   = 27;
  localparam int CTRL_W      = 28;

  // ALU operation codes
  localparam logic [3:0] ALU_NONE = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_INC  = 4'b0100;
  localparam logic [3:0] ALU_DIV  = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_OR   = 4'b0111;
  localparam logic [3:0] ALU_SHR  = 4'b1000;
  localparam logic [3:0] ALU_SHL  = 4'b1001;
  localparam logic [3:0] ALU_ROR  = 4'b1010;
  localparam logic [3:0] ALU_ROL  = 4'b1011;
  localparam logic [3:0] ALU_NEG  = 4'b1100;
  localparam logic [3:0] ALU_NOT  = 4'b1101;

  // ISA opcode map (0..26 legal)
  typedef enum logic [4:0] {
    OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3,
    OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_SHR  = 5'd7,
    OP_SHL  = 5'd8,  OP_ROR  = 5'd9,  OP_ROL  = 5'd10, OP_ADDI = 5'd11,
    OP_ANDI = 5'd12, OP_ORI  = 5'd13, OP_MUL  = 5'd14, OP_DIV  = 5'd15,
    OP_NEG  = 5'd16, OP_NOT  = 5'd17, OP_BR   = 5'd18, OP_JR   = 5'd19,
    OP_JAL  = 5'd20, OP_IN   = 5'd21, OP_OUT  = 5'd22, OP_MFHI = 5'd23,
    OP_MFLO = 5'd24, OP_NOP  = 5'd25, OP_HALT = 5'd26
  } opcode_e;

  // Micro-sequence classes
  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_IMM, C_UN, C_LD, C_ST, C_MD, C_BR,
    C_JAL, C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_HALT, C_ILL
  } class_e;

  typedef enum logic [2:0] {
    S_RESET, S_T0, S_T1, S_T2, S_EXEC, S_HALT, S_FAULT
  } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Opcode decoder: opcode -> micro-sequence class, ALU code, exec step count. Macro CTRL_ILLEGAL_TRAP_EN selects trap vs nop for opcodes above 26.
// Purely combinational, zero latency.
// No flow control.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  logic [OPC_W-1:0] opc,
  output class_e           cls,
  output logic [3:0]       alu,
  output logic [2:0]       nsteps
);

  // Table lookup of the ISA map; unknown opcodes fall to the default arm
  always_comb begin
    cls    = C_NOP;
    alu    = ALU_NONE;
    nsteps = 3'd1;
    case (opc)
      OP_LD:   begin cls = C_LD;  alu = ALU_ADD; nsteps = 3'd5; end
      OP_ST:   begin cls = C_ST;  alu = ALU_ADD; nsteps = 3'd5; end
      OP_ADD:  begin cls = C_ALU; alu = ALU_ADD; nsteps = 3'd3; end
      OP_SUB:  begin cls = C_ALU; alu = ALU_SUB; nsteps = 3'd3; end
      OP_AND:  begin cls = C_ALU; alu = ALU_AND; nsteps = 3'd3; end
      OP_OR:   begin cls = C_ALU; alu = ALU_OR;  nsteps = 3'd3; end
      OP_SHR:  begin cls = C_ALU; alu = ALU_SHR; nsteps = 3'd3; end
      OP_SHL:  begin cls = C_ALU; alu = ALU_SHL; nsteps = 3'd3; end
      OP_ROR:  begin cls = C_ALU; alu = ALU_ROR; nsteps = 3'd3; end
      OP_ROL:  begin cls = C_ALU; alu = ALU_ROL; nsteps = 3'd3; end
      OP_LDI:  begin cls = C_IMM; alu = ALU_ADD; nsteps = 3'd3; end
      OP_ADDI: begin cls = C_IMM; alu = ALU_ADD; nsteps = 3'd3; end
      OP_ANDI: begin cls = C_IMM; alu = ALU_AND; nsteps = 3'd3; end
      OP_ORI:  begin cls = C_IMM; alu = ALU_OR;  nsteps = 3'd3; end
      OP_NEG:  begin cls = C_UN;  alu = ALU_NEG; nsteps = 3'd3; end
      OP_NOT:  begin cls = C_UN;  alu = ALU_NOT; nsteps = 3'd3; end
      OP_MUL:  begin cls = C_MD;  alu = ALU_MUL; nsteps = 3'd4; end
      OP_DIV:  begin cls = C_MD;  alu = ALU_DIV; nsteps = 3'd4; end
      OP_BR:   begin cls = C_BR;  alu = ALU_ADD; nsteps = 3'd4; end
      OP_JAL:  begin cls = C_JAL; nsteps = 3'd2; end
      OP_JR:   begin cls = C_JR;   nsteps = 3'd1; end
      OP_IN:   begin cls = C_IN;   nsteps = 3'd1; end
      OP_OUT:  begin cls = C_OUT;  nsteps = 3'd1; end
      OP_MFHI: begin cls = C_MFHI; nsteps = 3'd1; end
      OP_MFLO: begin cls = C_MFLO; nsteps = 3'd1; end
      OP_NOP:  begin cls = C_NOP;  nsteps = 3'd1; end
      OP_HALT: begin cls = C_HALT; nsteps = 3'd1; end
      default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        cls    = C_ILL;
        nsteps = 3'd1;
`else
        cls    = C_NOP;
        nsteps = 3'd1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: fetch T0..T2, decode, per-class exec steps 3..7; registered Moore outputs. Optional CTRL_ILLEGAL_TRAP_EN traps opcodes > 26.
// Outputs change one edge after the state decision; every step lasts one cycle unless waiting on memory.
// Read/wren steps hold until mem_ack; WAIT_MAX unacknowledged cycles -> sticky FAULT.
module ctrl_seq
  import ctrl_pkg::*;
#(
  parameter int IR_W      = 32,
  parameter int OPC_MSB   = 31,
  parameter int OPC_W     = 5,
  parameter int ALU_SEL_W = 4,
  parameter int WAIT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IR_W-1:0]      IR,
  input  logic                 stop,
  input  logic                 conffout,
  input  logic                 mem_ack,
  output logic [CTRL_W-1:0]    ctrl,
  output logic [ALU_SEL_W-1:0] ALUselect,
  output logic                 Run,
  output logic                 fault
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);

  state_e               state_q, state_d;
  logic [2:0]           step_q, step_d, last_q, last_d;
  class_e               cls_q, cls_d;
  logic [3:0]           calu_q, calu_d;
  logic [WC_W-1:0]      wait_q, wait_d;
  logic                 stop_q, stop_d, fault_q, fault_d;
  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
  logic [ALU_SEL_W-1:0] alu_q, alu_d;
  logic                 run_q, run_d;

  class_e     dec_cls;
  logic [3:0] dec_alu;
  logic [2:0] dec_steps;
  logic       mem_wait;
  logic       ir_unused;

  // Only the opcode field steers sequencing; register fields go to the datapath
  assign ir_unused = ^IR;

  ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .opc    (IR[OPC_MSB -: OPC_W]),
    .cls    (dec_cls),
    .alu    (dec_alu),
    .nsteps (dec_steps)
  );

  // A memory step is one whose registered control word is driving read or wren
  assign mem_wait = ctrl_q[B_READ] | ctrl_q[B_WREN];

  // State and output registers; reset wins over waits and mid-instruction steps
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      step_q  <= '0;
      last_q  <= '0;
      cls_q   <= C_NOP;
      calu_q  <= ALU_NONE;
      wait_q  <= '0;
      stop_q  <= 1'b0;
      fault_q <= 1'b0;
      ctrl_q  <= '0;
      alu_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      last_q  <= last_d;
      cls_q   <= cls_d;
      calu_q  <= calu_d;
      wait_q  <= wait_d;
      stop_q  <= stop_d;
      fault_q <= fault_d;
      ctrl_q  <= ctrl_d;
      alu_q   <= alu_d;
      run_q   <= run_d;
    end
  end

  // Next state, then the control word for that next state (registered -> Moore)
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    cls_d   = cls_q;
    calu_d  = calu_q;
    wait_d  = wait_q;
    fault_d = fault_q;
    stop_d  = stop_q | (stop & (state_q != S_RESET));

    if (mem_wait && !mem_ack) begin
      if (wait_q >= WC_W'(WAIT_MAX - 1)) begin
        state_d = S_FAULT;
        fault_d = 1'b1;
        wait_d  = '0;
      end else begin
        wait_d = wait_q + WC_W'(1);
      end
    end else begin
      wait_d = '0;
      case (state_q)
        // clr is emitted for one cycle before fetch starts
        S_RESET: if (ctrl_q[B_CLR]) state_d = S_T0;
        S_T0:    state_d = S_T1;
        S_T1:    state_d = S_T2;
        S_T2: begin
          case (dec_cls)
            C_HALT: state_d = S_HALT;
            C_ILL: begin
              state_d = S_FAULT;
              fault_d = 1'b1;
            end
            default: begin
              state_d = S_EXEC;
              step_d  = 3'd3;
              cls_d   = dec_cls;
              calu_d  = dec_alu;
              last_d  = 3'd2 + dec_steps;
            end
          endcase
        end
        S_EXEC: begin
          if (step_q == last_q) begin
            step_d  = '0;
            state_d = (stop_q | stop) ? S_HALT : S_T0;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
        default: ;
      endcase
    end

    ctrl_d = '0;
    alu_d  = '0;
    run_d  = 1'b0;
    case (state_d)
      S_RESET: ctrl_d[B_CLR] = 1'b1;
      S_T0: begin
        run_d            = 1'b1;
        ctrl_d[B_PCOUT]  = 1'b1;
        ctrl_d[B_MARIN]  = 1'b1;
        ctrl_d[B_ZIN]    = 1'b1;
        alu_d            = ALU_SEL_W'(ALU_INC);
      end
      S_T1: begin
        run_d             = 1'b1;
        ctrl_d[B_ZLOWOUT] = 1'b1;
        ctrl_d[B_PCIN]    = 1'b1;
        ctrl_d[B_READ]    = 1'b1;
        ctrl_d[B_MDRIN]   = 1'b1;
      end
      S_T2: begin
        run_d            = 1'b1;
        ctrl_d[B_MDROUT] = 1'b1;
        ctrl_d[B_IRIN]   = 1'b1;
      end
      S_EXEC: begin
        run_d = 1'b1;
        case (cls_d)
          C_ALU, C_IMM, C_UN: begin
            case (step_d)
              3'd3: begin
                ctrl_d[B_GRB] = 1'b1; ctrl_d[B_ROUT] = 1'b1; ctrl_d[B_YIN] = 1'b1;
              end
              3'd4: begin
                ctrl_d[B_ZIN] = 1'b1;
                alu_d = ALU_SEL_W'(calu_d);
                if (cls_d == C_ALU) begin
                  ctrl_d[B_GRC] = 1'b1; ctrl_d[B_ROUT] = 1'b1;
                end else if (cls_d == C_IMM) begin
                  ctrl_d[B_COUT] = 1'b1;
                end else begin
                  ctrl_d[B_GRB] = 1'b1; ctrl_d[B_ROUT] = 1'b1;
                end
              end
              3'd5: begin
                ctrl_d[B_ZLOWOUT] = 1'b1; ctrl_d[B_GRA] = 1'b1; ctrl_d[B_RIN] = 1'b1;
              end
              default: ;
            endcase
          end
          C_LD, C_ST: begin
            case (step_d)
              3'd3: begin
                ctrl_d[B_GRB] = 1'b1; ctrl_d[B_BAOUT] = 1'b1; ctrl_d[B_YIN] = 1'b1;
              end
              3'd4: begin
                ctrl_d[B_COUT] = 1'b1; ctrl_d[B_ZIN] = 1'b1;
                alu_d = ALU_SEL_W'(calu_d);
              end
              3'd5: begin
                ctrl_d[B_ZLOWOUT] = 1'b1; ctrl_d[B_MARIN] = 1'b1;
              end
              3'd6: begin
                ctrl_d[B_MDRIN] = 1'b1;
                if (cls_d == C_LD) begin
                  ctrl_d[B_READ] = 1'b1;
                end else begin
                  ctrl_d[B_GRA] = 1'b1; ctrl_d[B_ROUT] = 1'b1;
                end
              end
              3'd7: begin
                if (cls_d == C_LD) begin
                  ctrl_d[B_MDROUT] = 1'b1; ctrl_d[B_GRA] = 1'b1; ctrl_d[B_RIN] = 1'b1;
                end else begin
                  ctrl_d[B_WREN] = 1'b1;
                end
              end
              default: ;
            endcase
          end
          C_MD: begin
            case (step_d)
              3'd3: begin
                ctrl_d[B_GRA] = 1'b1; ctrl_d[B_ROUT] = 1'b1; ctrl_d[B_YIN] = 1'b1;
              end
              3'd4: begin
                ctrl_d[B_GRB] = 1'b1; ctrl_d[B_ROUT] = 1'b1; ctrl_d[B_ZIN] = 1'b1;
                alu_d = ALU_SEL_W'(calu_d);
              end
              3'd5: begin
                ctrl_d[B_ZLOWOUT] = 1'b1; ctrl_d[B_LOIN] = 1'b1;
              end
              3'd6: begin
                ctrl_d[B_ZHIGHOUT] = 1'b1; ctrl_d[B_HIIN] = 1'b1;
              end
              default: ;
            endcase
          end
          C_BR: begin
            case (step_d)
              3'd3: begin
                ctrl_d[B_GRA] = 1'b1; ctrl_d[B_ROUT] = 1'b1; ctrl_d[B_CONFFIN] = 1'b1;
              end
              3'd4: begin
                ctrl_d[B_PCOUT] = 1'b1; ctrl_d[B_YIN] = 1'b1;
              end
              3'd5: begin
                ctrl_d[B_COUT] = 1'b1; ctrl_d[B_ZIN] = 1'b1;
                alu_d = ALU_SEL_W'(calu_d);
              end
              3'd6: begin
                // Branch target always on the bus; PC only captures it when taken
                ctrl_d[B_ZLOWOUT] = 1'b1;
                ctrl_d[B_PCIN]    = conffout;
              end
              default: ;
            endcase
          end
          C_JAL: begin
            if (step_d == 3'd3) begin
              ctrl_d[B_PCOUT] = 1'b1; ctrl_d[B_GRB] = 1'b1; ctrl_d[B_RIN] = 1'b1;
            end else begin
              ctrl_d[B_GRA] = 1'b1; ctrl_d[B_ROUT] = 1'b1; ctrl_d[B_PCIN] = 1'b1;
            end
          end
          C_JR: begin
            ctrl_d[B_GRA] = 1'b1; ctrl_d[B_ROUT] = 1'b1; ctrl_d[B_PCIN] = 1'b1;
          end
          C_IN: begin
            ctrl_d[B_INPORTOUT] = 1'b1; ctrl_d[B_GRA] = 1'b1; ctrl_d[B_RIN] = 1'b1;
          end
          C_OUT: begin
            ctrl_d[B_GRA] = 1'b1; ctrl_d[B_ROUT] = 1'b1; ctrl_d[B_OPIN] = 1'b1;
          end
          C_MFHI: begin
            ctrl_d[B_HIOUT] = 1'b1; ctrl_d[B_GRA] = 1'b1; ctrl_d[B_RIN] = 1'b1;
          end
          C_MFLO: begin
            ctrl_d[B_LOOUT] = 1'b1; ctrl_d[B_GRA] = 1'b1; ctrl_d[B_RIN] = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign ctrl      = ctrl_q;
  assign ALUselect = alu_q;
  assign Run       = run_q;
  assign fault     = fault_q;

endmodule
